attr_number_parser: RTL and testbench

// - Streaming parser for numeric HTML attribute values (width, height, border, color, size).
// - Successor to the decimal-only attribute integer parser, adding:
//   - configurable width;
//   - '#' hex mode;
//   - "px" / "%" unit suffixes;
//   - leading-quote skipping;
//   - saturation with an overflow flag;
//   - syntax-error detection;
//   - a valid/ready character handshake.
// - Sits between the tag tokenizer (char source) and the attribute register file (value sink).

---
 rtl/attr_number_parser_pkg.sv | 35 +++
 rtl/attr_number_parser_if.sv | 31 +++
 rtl/attr_number_parser_char_class.sv | 30 +++
 rtl/attr_number_parser.sv | 209 ++++++++++++++++++++
 tb/tb_attr_number_parser.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/attr_number_parser_pkg.sv
// Shared definitions for the numeric attribute parser.
// Contents: default widths, ASCII character codes and FSM state encodings.
package attr_number_parser_pkg;

    localparam int unsigned CHAR_BITS = 8;
    localparam int unsigned ATTR_VAL_BITS = 10;

    // ASCII codes the parser reacts to
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_GT     = 8'h3e;
    localparam logic [7:0] CH_SLASH  = 8'h2f;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_DQUOTE = 8'h22;
    localparam logic [7:0] CH_SQUOTE = 8'h27;
    localparam logic [7:0] CH_PCT    = 8'h25;
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;
    localparam logic [7:0] CH_LA     = 8'h61;
    localparam logic [7:0] CH_LF     = 8'h66;
    localparam logic [7:0] CH_UA     = 8'h41;
    localparam logic [7:0] CH_UF     = 8'h46;
    localparam logic [7:0] CH_P      = 8'h70;
    localparam logic [7:0] CH_X      = 8'h78;

    // Parser state encodings
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLead    = 3'd1;
    localparam logic [2:0] StDec     = 3'd2;
    localparam logic [2:0] StHex     = 3'd3;
    localparam logic [2:0] StSufP    = 3'd4;
    localparam logic [2:0] StSufDone = 3'd5;
    localparam logic [2:0] StDone    = 3'd6;
    localparam logic [2:0] StError   = 3'd7;

endpackage

// File: rtl/attr_number_parser_if.sv
// Character handshake and result bundle between the tag tokenizer (master) and the
// numeric attribute parser (slave).
// Signals: enable, char_valid, char_data (tokenizer -> parser); char_ready, value,
// has_finished, is_hex, is_percent, overflow, error (parser -> tokenizer / register file).
interface attr_number_parser_if
    import attr_number_parser_pkg::*;
#(
    parameter int unsigned CHAR_WIDTH = CHAR_BITS,
    parameter int unsigned VAL_WIDTH  = ATTR_VAL_BITS
);
    logic                  enable;
    logic                  char_valid;
    logic [CHAR_WIDTH-1:0] char_data;
    logic                  char_ready;
    logic [VAL_WIDTH-1:0]  value;
    logic                  has_finished;
    logic                  is_hex;
    logic                  is_percent;
    logic                  overflow;
    logic                  error;

    modport master (
        output enable, char_valid, char_data,
        input  char_ready, value, has_finished, is_hex, is_percent, overflow, error
    );

    modport slave (
        input  enable, char_valid, char_data,
        output char_ready, value, has_finished, is_hex, is_percent, overflow, error
    );
endinterface

// File: rtl/attr_number_parser_char_class.sv
// Combinational character classifier for the attribute parser.
// Ports: char_data (in) -> is_dec, is_hex_digit, is_term, is_quote, nibble (digit value).
module attr_number_parser_char_class
    import attr_number_parser_pkg::*;
#(
    parameter int unsigned CHAR_WIDTH = CHAR_BITS
) (
    input  logic [CHAR_WIDTH-1:0] char_data,
    output logic                  is_dec,
    output logic                  is_hex_digit,
    output logic                  is_term,
    output logic                  is_quote,
    output logic [3:0]            nibble
);
    logic is_lower_hex;
    logic is_upper_hex;

    always_comb begin
        is_dec       = (char_data >= CHAR_WIDTH'(CH_0)) && (char_data <= CHAR_WIDTH'(CH_9));
        is_lower_hex = (char_data >= CHAR_WIDTH'(CH_LA)) && (char_data <= CHAR_WIDTH'(CH_LF));
        is_upper_hex = (char_data >= CHAR_WIDTH'(CH_UA)) && (char_data <= CHAR_WIDTH'(CH_UF));
        is_hex_digit = is_dec | is_lower_hex | is_upper_hex;
        is_term      = (char_data == CHAR_WIDTH'(CH_SPACE)) || (char_data == CHAR_WIDTH'(CH_GT))
                    || (char_data == CHAR_WIDTH'(CH_SLASH));
        is_quote     = (char_data == CHAR_WIDTH'(CH_DQUOTE))
                    || (char_data == CHAR_WIDTH'(CH_SQUOTE));
        // 'a'..'f' and 'A'..'F' both carry 1..6 in their low nibble
        nibble       = is_dec ? char_data[3:0] : char_data[3:0] + 4'd9;
    end
endmodule

// File: rtl/attr_number_parser.sv
// Streaming parser for numeric HTML attribute values (decimal, '#' hex, "px"/"%" suffixes,
// optional surrounding quotes) with saturation and syntax-error detection.
// Ports: clock, resetn (async, active-low), bus (attr_number_parser_if.slave): character
// handshake in, registered value and status flags out.
module attr_number_parser
    import attr_number_parser_pkg::*;
#(
    parameter int unsigned CHAR_WIDTH = CHAR_BITS,
    parameter int unsigned VAL_WIDTH  = ATTR_VAL_BITS,
    parameter int unsigned MAX_DIGITS = 8,
    parameter bit          ALLOW_HEX  = 1'b1
) (
    input logic                 clock,
    input logic                 resetn,
    attr_number_parser_if.slave bus
);
    localparam int unsigned AccW = VAL_WIDTH + 4;
    localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

    logic [2:0]           state_q, state_d;
    logic [VAL_WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 seen_q, seen_d;    // at least one digit, zeros included
    logic                 qopen_q, qopen_d;  // opening quote awaiting its partner
    logic                 hex_q, hex_d;
    logic                 pct_q, pct_d;
    logic                 ovf_q, ovf_d;

    logic       is_dec, is_hex_digit, is_term, is_quote;
    logic [3:0] nibble;
    logic       is_hash, is_p, is_x, is_pct;
    logic       go_err, take_digit, counts, dig_over, sat, finished;
    logic [AccW-1:0] acc_w, nxt_w;

    attr_number_parser_char_class #(
        .CHAR_WIDTH(CHAR_WIDTH)
    ) u_char_class (
        .char_data   (bus.char_data),
        .is_dec      (is_dec),
        .is_hex_digit(is_hex_digit),
        .is_term     (is_term),
        .is_quote    (is_quote),
        .nibble      (nibble)
    );

    assign is_hash  = bus.char_data == CHAR_WIDTH'(CH_HASH);
    assign is_p     = bus.char_data == CHAR_WIDTH'(CH_P);
    assign is_x     = bus.char_data == CHAR_WIDTH'(CH_X);
    assign is_pct   = bus.char_data == CHAR_WIDTH'(CH_PCT);
    assign finished = (state_q == StDone) || (state_q == StError);

    // Terminators are left for the tokenizer, which sees them after dropping enable
    assign bus.char_ready   = bus.enable & bus.char_valid & ~finished & ~is_term;
    assign bus.value        = acc_q;
    assign bus.has_finished = finished;
    assign bus.error        = state_q == StError;
    assign bus.is_hex       = hex_q;
    assign bus.is_percent   = pct_q;
    assign bus.overflow     = ovf_q;

    // Accumulator step; acc_q never exceeds 2^VAL_WIDTH-1 so four spare bits suffice
    always_comb begin
        acc_w    = AccW'(acc_q);
        nxt_w    = (state_q == StHex) ? ((acc_w << 4) | AccW'(nibble))
                                      : ((acc_w << 3) + (acc_w << 1) + AccW'(nibble));
        sat      = nxt_w > AccW'({VAL_WIDTH{1'b1}});
        counts   = (nibble != 4'd0) || (cnt_q != '0);  // leading zeros are free
        dig_over = counts && (cnt_q == CntW'(MAX_DIGITS));
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        qopen_d    = qopen_q;
        hex_d      = hex_q;
        pct_d      = pct_q;
        ovf_d      = ovf_q;
        go_err     = 1'b0;
        take_digit = 1'b0;

        if (!bus.enable) begin
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = '0;
            seen_d  = 1'b0;
            qopen_d = 1'b0;
            hex_d   = 1'b0;
            pct_d   = 1'b0;
            ovf_d   = 1'b0;
        end else if (bus.char_valid) begin
            case (state_q)
                // IDLE already accepts the first character so no cycle is lost on entry
                StIdle, StLead: begin
                    if (is_quote && !qopen_q) begin
                        qopen_d = 1'b1;
                        state_d = StLead;
                    end else if (is_dec) begin
                        take_digit = 1'b1;
                        state_d    = StDec;
                    end else if (is_hash && ALLOW_HEX) begin
                        hex_d   = 1'b1;
                        state_d = StHex;
                    end else begin
                        go_err = 1'b1;  // terminator, second quote or junk
                    end
                end
                StDec: begin
                    if (is_term) begin
                        state_d = StDone;
                    end else if (is_dec) begin
                        take_digit = 1'b1;
                    end else if (is_p) begin
                        state_d = StSufP;
                    end else if (is_pct) begin
                        pct_d   = 1'b1;
                        state_d = StSufDone;
                    end else if (is_quote && qopen_q) begin
                        qopen_d = 1'b0;
                        state_d = StSufDone;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                StHex: begin
                    if (is_term && seen_q) begin
                        state_d = StDone;
                    end else if (is_hex_digit) begin
                        take_digit = 1'b1;
                    end else if (is_quote && qopen_q && seen_q) begin
                        qopen_d = 1'b0;
                        state_d = StSufDone;
                    end else begin
                        go_err = 1'b1;  // includes "#" followed directly by a terminator
                    end
                end
                StSufP: begin
                    if (is_x) begin
                        state_d = StSufDone;
                    end else begin
                        go_err = 1'b1;
                    end
                end
                StSufDone: begin
                    if (is_term) begin
                        state_d = StDone;
                    end else if (is_quote && qopen_q) begin
                        qopen_d = 1'b0;  // closing quote after a unit suffix
                    end else begin
                        go_err = 1'b1;
                    end
                end
                StDone, StError: ;  // sticky until enable drops
                default: state_d = StIdle;
            endcase
        end else if (state_q == StIdle) begin
            state_d = StLead;
        end

        if (take_digit) begin
            if (dig_over) begin
                go_err = 1'b1;
            end else begin
                cnt_d  = cnt_q + CntW'(counts);
                seen_d = 1'b1;
                // Once saturated the accumulator stays all-ones while digits keep coming
                if (!ovf_q) begin
                    if (sat) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = nxt_w[VAL_WIDTH-1:0];
                    end
                end
            end
        end

        if (go_err) begin
            state_d = StError;
            acc_d   = '0;
            hex_d   = 1'b0;
            pct_d   = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            qopen_q <= 1'b0;
            hex_q   <= 1'b0;
            pct_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            qopen_q <= qopen_d;
            hex_q   <= hex_d;
            pct_q   <= pct_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_attr_number_parser.sv
// Self-checking bench for attr_number_parser: one instance with hex enabled, one with hex
// disabled sharing the same character stream; expectations come from a string-level model.
module tb_attr_number_parser;
    import attr_number_parser_pkg::*;

    typedef struct packed {
        logic [9:0] value;
        logic       hex;
        logic       pct;
        logic       ovf;
        logic       err;
    } exp_t;

    logic clock;
    logic resetn;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    attr_number_parser_if #(.CHAR_WIDTH(8), .VAL_WIDTH(10)) bus0 ();
    attr_number_parser_if #(.CHAR_WIDTH(8), .VAL_WIDTH(10)) bus1 ();

    assign bus1.enable     = bus0.enable;
    assign bus1.char_valid = bus0.char_valid;
    assign bus1.char_data  = bus0.char_data;

    attr_number_parser #(
        .CHAR_WIDTH(8), .VAL_WIDTH(10), .MAX_DIGITS(8), .ALLOW_HEX(1'b1)
    ) u_dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus0)
    );

    attr_number_parser #(
        .CHAR_WIDTH(8), .VAL_WIDTH(10), .MAX_DIGITS(8), .ALLOW_HEX(1'b0)
    ) u_dut_nohex (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_term(input byte c);
        return (c == " ") || (c == ">") || (c == "/");
    endfunction

    function automatic bit m_quote(input byte c);
        return (c == "\"") || (c == "'");
    endfunction

    function automatic int m_digit(input byte c, input bit hex);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (hex && c >= "a" && c <= "f") return int'(c) - 87;
        if (hex && c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    // Reference: grammar  [quote] ['#'] digits [px|%] [quote] terminator
    function automatic exp_t model(input string s, input bit allow_hex);
        exp_t   r;
        int     i = 0;
        int     n = s.len();
        bit     quoted = 0, hex = 0, pct = 0, bad = 0;
        longint acc = 0;
        int     nsig = 0, ndig = 0, d;
        r = '0;
        if (i < n && m_quote(s[i])) begin quoted = 1; i++; end
        if (i < n && s[i] == "#") begin
            if (!allow_hex) bad = 1;
            hex = 1;
            i++;
        end
        while (!bad && i < n && m_digit(s[i], hex) >= 0) begin
            d = m_digit(s[i], hex);
            if (d != 0 || nsig != 0) nsig++;
            if (nsig > 8) bad = 1;
            acc = acc * (hex ? 16 : 10) + d;
            ndig++;
            i++;
        end
        if (ndig == 0) bad = 1;
        if (!bad && !hex && i + 1 < n && s[i] == "p" && s[i+1] == "x") begin
            i += 2;
        end else if (!bad && !hex && i < n && s[i] == "%") begin
            pct = 1;
            i++;
        end
        if (!bad && quoted) begin
            if (i < n && m_quote(s[i])) i++;
            else bad = 1;
        end
        if (!bad && i < n && !m_term(s[i])) bad = 1;
        if (bad) begin
            r.err = 1'b1;
        end else begin
            r.value = (acc > 1023) ? 10'd1023 : acc[9:0];
            r.ovf   = acc > 1023;
            r.hex   = hex;
            r.pct   = pct;
        end
        return r;
    endfunction

    function automatic logic [15:0] outs0();
        return {bus0.value, bus0.has_finished, bus0.is_hex, bus0.is_percent, bus0.overflow,
                bus0.error, bus0.char_ready};
    endfunction

    task automatic drop_enable(input string tag);
        bus0.char_valid = 1'b0;
        bus0.enable     = 1'b0;
        @(posedge clock); #1;
        check_eq({tag, ":cleared"}, 32'(outs0()), 32'd0);
        bus0.enable = 1'b1;
    endtask

    task automatic run_vec(input string s, input bit bubbles);
        exp_t e0, e1;
        int   i = 0;
        int   cyc = 0;
        bit   rdy;
        bit   fin = 0;
        q0.push_back(model(s, 1'b1));
        q1.push_back(model(s, 1'b0));
        while (!fin && cyc < 200) begin
            bus0.char_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            bus0.char_data  = (i < s.len()) ? s[i] : 8'h20;
            #1;
            rdy = bus0.char_ready;
            if (bus0.char_valid && m_term(bus0.char_data))
                check_eq({s, ":term_ready"}, 32'(rdy), 32'd0);
            @(posedge clock); #1;
            cyc++;
            if (rdy) i++;
            fin = bus0.has_finished;
        end
        bus0.char_valid = 1'b0;
        check_eq({s, ":finished"}, 32'(fin), 32'd1);
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check_eq({s, ":value"}, 32'(bus0.value), 32'(e0.value));
        check_eq({s, ":flags"}, {28'd0, bus0.is_hex, bus0.is_percent, bus0.overflow, bus0.error},
                 {28'd0, e0.hex, e0.pct, e0.ovf, e0.err});
        check_eq({s, ":nohex_result"},
                 {17'd0, bus1.has_finished, bus1.value, bus1.is_hex, bus1.is_percent,
                  bus1.overflow, bus1.error},
                 {17'd0, 1'b1, e1.value, e1.hex, e1.pct, e1.ovf, e1.err});
        drop_enable(s);
    endtask

    task automatic drive_chars(input string s);
        for (int k = 0; k < s.len(); k++) begin
            bus0.char_valid = 1'b1;
            bus0.char_data  = s[k];
            @(posedge clock); #1;
        end
        bus0.char_valid = 1'b0;
    endtask

    string vecs[$] = '{"123 ", "2000>", "#1aF ", "\"50%\" ", "12px>", "1x2 ", "#>", ">",
                       "1023 ", "1024/", "#3FF>", "#400 ", "000000001234 ", "12345678 ",
                       "123456789 ", "'7'/", "0>", "\"\"5 ", "12p ", "#000000001 ", "\"9px\">"};

    initial begin
        resetn          = 1'b0;
        bus0.enable     = 1'b0;
        bus0.char_valid = 1'b0;
        bus0.char_data  = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        check_eq("reset_outputs", 32'(outs0()), 32'd0);
        resetn = 1'b1;
        @(posedge clock); #1;
        bus0.enable = 1'b1;

        foreach (vecs[k]) run_vec(vecs[k], 1'b0);
        for (int r = 0; r < 3; r++) run_vec("123 ", 1'b1);
        run_vec("#1aF ", 1'b1);

        // Enable dropped mid-parse, then a fresh value
        drive_chars("45");
        drop_enable("drop_after_45");
        run_vec("7 ", 1'b0);

        // Asynchronous reset mid-parse
        drive_chars("#12");
        #3;
        resetn = 1'b0;
        #1;
        check_eq("async_reset_outputs", 32'(outs0()), 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        run_vec("7 ", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
